mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_if.sv | 34 +++
 rtl/mem_req_ctrl.sv | 114 +++++++++++
 tb/tb_mem_req_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl_if
// Bundles the requester handshake (req_*/rsp_*) and the single-port RAM bus
// (address/data/write_enable/data_out) served by mem_req_ctrl.
//   slave  : controller view (takes requests and RAM read data, drives the RAM
//            bus and responses)
//   master : environment view (requester plus RAM)
// -----------------------------------------------------------------------------
interface mem_req_ctrl_if;
   // requester side
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [14:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   // RAM side
   logic [14:0] address;
   logic [15:0] data;
   logic        write_enable;
   logic [15:0] data_out;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, data_out,
      output req_ready, rsp_valid, rsp_rdata, address, data, write_enable
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, data_out,
      input  req_ready, rsp_valid, rsp_rdata, address, data, write_enable
   );
endinterface

// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
// Turns a valid/ready request stream into single-port RAM accesses. Writes
// pulse write_enable for one cycle and return no response; reads wait out the
// RAM latency, capture data_out and hold it on rsp_* until the requester
// takes it. One transaction in flight at a time.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_req_ctrl_if.slave (request/response handshake + RAM bus)
// Parameter RD_LATENCY (1..4): clock edges from a registered RAM address to
// valid data_out.
// -----------------------------------------------------------------------------
module mem_req_ctrl #(
   parameter int RD_LATENCY = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_req_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [14:0] addr_q, addr_nxt;
   logic [15:0] data_q, data_nxt;
   logic [15:0] rdata_q, rdata_nxt;
   logic        we_q, we_nxt;
   logic        rv_q, rv_nxt;

   // Ready is a pure decode of the state register: no request is taken while
   // a write strobe, read wait or pending response is outstanding.
   assign bus.req_ready    = (state == IDLE);

   assign bus.address      = addr_q;
   assign bus.data         = data_q;
   assign bus.write_enable = we_q;
   assign bus.rsp_valid    = rv_q;
   assign bus.rsp_rdata    = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         addr_q  <= addr_nxt;
         data_q  <= data_nxt;
         rdata_q <= rdata_nxt;
         we_q    <= we_nxt;
         rv_q    <= rv_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      rdata_nxt = rdata_q;
      we_nxt    = 1'b0;          // strobe only ever set on the way into WRITE
      rv_nxt    = rv_q;

      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               addr_nxt = bus.req_addr;
               if (bus.req_we) begin
                  data_nxt  = bus.req_wdata;
                  we_nxt    = 1'b1;
                  state_nxt = WRITE;
               end else begin
                  cnt_nxt   = 3'(RD_LATENCY);
                  state_nxt = READ;
               end
            end
         end

         WRITE: begin
            state_nxt = IDLE;
         end

         READ: begin
            // The counter runs out on the RAM's last latency edge; capturing
            // one edge later samples data_out after it has settled.
            if (cnt == 3'd0) begin
               rdata_nxt = bus.data_out;
               rv_nxt    = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               rv_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_req_ctrl
// Directed bench for mem_req_ctrl. Two instances (RD_LATENCY 1 and 4) each
// sit on a behavioural RAM; 'sel' routes the shared stimulus to one of them
// and picks which outputs are observed.
// -----------------------------------------------------------------------------
module tb_mem_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        rsp_ready = 1'b0;
   logic [14:0] req_addr = '0;
   logic [15:0] req_wdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_req_ctrl_if b1();
   mem_req_ctrl_if b4();

   mem_req_ctrl #(.RD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   mem_req_ctrl #(.RD_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

   assign b1.req_valid = req_valid & ~sel;
   assign b1.req_we    = req_we;
   assign b1.req_addr  = req_addr;
   assign b1.req_wdata = req_wdata;
   assign b1.rsp_ready = rsp_ready & ~sel;
   assign b4.req_valid = req_valid & sel;
   assign b4.req_we    = req_we;
   assign b4.req_addr  = req_addr;
   assign b4.req_wdata = req_wdata;
   assign b4.rsp_ready = rsp_ready & sel;

   // RAMs: read data valid RD_LATENCY edges after the address is presented
   logic [15:0] mem1 [0:32767];
   logic [15:0] p1;
   always @(posedge clk) begin
      if (b1.write_enable) mem1[b1.address] <= b1.data;
      p1 <= mem1[b1.address];
   end
   assign b1.data_out = p1;

   logic [15:0] mem4 [0:32767];
   logic [15:0] p4 [0:3];
   always @(posedge clk) begin
      if (b4.write_enable) mem4[b4.address] <= b4.data;
      p4[0] <= mem4[b4.address];
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   assign b4.data_out = p4[3];

   logic        o_rdy, o_rv, o_we;
   logic [14:0] o_addr;
   logic [15:0] o_data, o_rdata;
   assign o_rdy   = sel ? b4.req_ready    : b1.req_ready;
   assign o_rv    = sel ? b4.rsp_valid    : b1.rsp_valid;
   assign o_we    = sel ? b4.write_enable : b1.write_enable;
   assign o_addr  = sel ? b4.address      : b1.address;
   assign o_data  = sel ? b4.data         : b1.data;
   assign o_rdata = sel ? b4.rsp_rdata    : b1.rsp_rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // called right after the accept edge; counts edges until rsp_valid
   task automatic wait_rsp(input int exp_edges, input logic [15:0] exp_data, input string tag);
      int n = 0;
      while (!o_rv && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, exp_edges);
      chk({tag, "_rdata"}, o_rdata, exp_data);
   endtask

   // write 0x7FFF then read it back with req_valid held high
   task automatic b2b(input int lat);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h7FFF; req_wdata = 16'h1234;
      tick();
      chk("b2b_we",    o_we, 1);
      chk("b2b_addr",  o_addr, 15'h7FFF);
      chk("b2b_data",  o_data, 16'h1234);
      chk("b2b_rdy0",  o_rdy, 0);
      req_we = 1'b0; req_wdata = 16'hFFFF;
      tick();
      chk("b2b_we_off", o_we, 0);
      chk("b2b_rdy1",   o_rdy, 1);
      tick();
      chk("b2b_rd_acc", o_rdy, 0);
      req_valid = 1'b0; req_addr = 15'h0; rsp_ready = 1'b1;
      wait_rsp(lat + 1, 16'h1234, "b2b");
      tick();
      chk("b2b_rv_done",  o_rv, 0);
      chk("b2b_rdy_done", o_rdy, 1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int seen;
      // reset state, asynchronously applied
      #1 rst_n = 1'b0;
      #2;
      chk("rst_rdy",   o_rdy, 1);
      chk("rst_we",    o_we, 0);
      chk("rst_rv",    o_rv, 0);
      chk("rst_addr",  o_addr, 0);
      chk("rst_data",  o_data, 0);
      chk("rst_rdata", o_rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rel_rdy", o_rdy, 1);
      tick();

      // write 0x1A3B <- 0xAAAA
      req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h1A3B; req_wdata = 16'hAAAA;
      tick();
      chk("wr_we",   o_we, 1);
      chk("wr_addr", o_addr, 15'h1A3B);
      chk("wr_data", o_data, 16'hAAAA);
      chk("wr_rdy",  o_rdy, 0);
      req_valid = 1'b0; req_we = 1'b0; req_addr = 15'h0555; req_wdata = 16'h5555;
      tick();
      chk("wr_pulse",     o_we, 0);
      chk("wr_rdy_back",  o_rdy, 1);
      chk("wr_addr_hold", o_addr, 15'h1A3B);
      chk("wr_data_hold", o_data, 16'hAAAA);

      // read back under backpressure
      req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h1A3B; rsp_ready = 1'b0;
      tick();
      chk("rd_we",   o_we, 0);
      chk("rd_addr", o_addr, 15'h1A3B);
      req_valid = 1'b0; req_addr = 15'h2222; req_we = 1'b1;
      wait_rsp(2, 16'hAAAA, "rd");
      chk("rd_data_hold", o_data, 16'hAAAA);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rv",    o_rv, 1);
         chk("bp_rdata", o_rdata, 16'hAAAA);
         chk("bp_rdy",   o_rdy, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_rel_rv",  o_rv, 0);
      chk("bp_rel_rdy", o_rdy, 1);
      tick();
      chk("idle_rr_rv",  o_rv, 0);
      chk("idle_rr_rdy", o_rdy, 1);
      rsp_ready = 1'b0;

      // reset in the middle of a write strobe
      req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h0100; req_wdata = 16'hBEEF;
      tick();
      chk("rw_we", o_we, 1);
      req_valid = 1'b0; req_we = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rw_we_async", o_we, 0);
      chk("rw_addr",     o_addr, 0);
      chk("rw_data",     o_data, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         tick();
         seen = seen | o_rv | o_we;
      end
      chk("rw_quiet", seen, 0);

      // reset in the middle of a read wait
      req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h1A3B; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("ra_rv", o_rv, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         tick();
         seen = seen | o_rv;
      end
      chk("ra_quiet", seen, 0);
      chk("ra_rdy",   o_rdy, 1);
      rsp_ready = 1'b0;

      // boundary address, back-to-back, both latencies
      b2b(1);
      sel = 1'b1;
      tick();
      chk("l4_idle_rdy", o_rdy, 1);
      b2b(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
